// File: rtl/tap_bit_player.sv
// tap_bit_player: plays a TAP image from the tape cache as an Oric fast-format
// serial waveform. Each byte becomes start(0), d0..d7, odd parity, STOP_BITS
// ones. Every bit is a high half of HALF_TICKS, then a low half of HALF_TICKS
// for a '1' or 2*HALF_TICKS for a '0'.
//
// Read handshake: rd_en is a single-cycle strobe issued in FETCH with rd_addr
// holding the byte address. The cache returns rd_data exactly one cycle later.
// That cycle is always LATCH, and LATCH captures the byte. rd_addr stays stable
// from FETCH through LATCH. There is no back-pressure: a FETCH always completes,
// even when en drops, so the read is never lost.
module tap_bit_player #(
   parameter int HALF_TICKS = 4992,
   parameter int STOP_BITS  = 3
) (
   input  logic        clk_sys,
   input  logic        RESET,
   input  logic        rewind,
   input  logic        en,
   input  logic [24:0] tape_end,
   output logic [24:0] rd_addr,
   output logic        rd_en,
   input  logic [7:0]  rd_data,
   output logic        data,
   output logic        busy,
   output logic        done,
   output logic [2:0]  dbg_state
);

   localparam int          FRAME_BITS = 10 + STOP_BITS;
   localparam logic [4:0]  LAST_BIT   = 5'(FRAME_BITS - 1);
   localparam logic [16:0] TICK_ONE   = 17'(HALF_TICKS - 1);
   localparam logic [16:0] TICK_ZERO  = 17'(2 * HALF_TICKS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_LATCH  = 3'd2,
      S_BIT_HI = 3'd3,
      S_BIT_LO = 3'd4,
      S_NEXT   = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [24:0] addr_q;
   logic [16:0] tick_q;
   logic [4:0]  bit_idx_q;
   logic [16:0] frame_q;
   logic [16:0] new_frame;
   logic        data_q;

   logic        clear;
   logic        cur_bit;
   logic [16:0] lo_limit;
   logic        hi_end;
   logic        lo_end;
   logic        last_bit;
   logic        at_end;

   assign clear    = RESET | rewind;
   assign cur_bit  = frame_q[bit_idx_q];
   assign lo_limit = cur_bit ? TICK_ONE : TICK_ZERO;
   assign hi_end   = (tick_q == TICK_ONE);
   assign lo_end   = (tick_q == lo_limit);
   assign last_bit = (bit_idx_q == LAST_BIT);
   assign at_end   = (addr_q == tape_end);

   // Assemble the serial frame. Bit 0 is the start bit, and the unused upper bits are never played.
   always_comb begin
      new_frame      = '1;
      new_frame[0]   = 1'b0;
      new_frame[8:1] = rd_data;
      new_frame[9]   = ~^rd_data;
   end

   // State register: rewind/RESET force IDLE from any state.
   always_ff @(posedge clk_sys) begin
      if (clear) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic: en gates every timed state; FETCH and LATCH always run through.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (en) state_d = S_FETCH;
         S_FETCH:  state_d = S_LATCH;
         S_LATCH:  state_d = S_BIT_HI;
         S_BIT_HI: if (en && hi_end) state_d = S_BIT_LO;
         S_BIT_LO: if (en && lo_end) state_d = S_NEXT;
         S_NEXT: begin
            if (en) begin
               if (!last_bit)   state_d = S_BIT_HI;
               else if (at_end) state_d = S_DONE;
               else             state_d = S_FETCH;
            end
         end
         S_DONE:   state_d = S_DONE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath: address, tick counter, bit index, frame capture and the data flop.
   always_ff @(posedge clk_sys) begin
      if (clear) begin
         addr_q    <= '0;
         tick_q    <= '0;
         bit_idx_q <= '0;
         frame_q   <= '0;
         data_q    <= 1'b0;
      end else begin
         // data follows the state one cycle later, so a frozen state also freezes the level
         data_q <= (state_q == S_BIT_HI);
         case (state_q)
            S_LATCH: begin
               frame_q   <= new_frame;
               bit_idx_q <= '0;
               tick_q    <= '0;
            end
            S_BIT_HI: if (en) tick_q <= hi_end ? 17'd0 : tick_q + 17'd1;
            S_BIT_LO: if (en) tick_q <= lo_end ? 17'd0 : tick_q + 17'd1;
            S_NEXT: begin
               if (en) begin
                  if (last_bit) begin
                     bit_idx_q <= '0;
                     if (!at_end) addr_q <= addr_q + 25'd1;
                  end else begin
                     bit_idx_q <= bit_idx_q + 5'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Output decode: taken only from registers, so no input reaches an output combinationally.
   always_comb begin
      rd_addr   = addr_q;
      rd_en     = (state_q == S_FETCH);
      data      = data_q;
      busy      = (state_q != S_IDLE) && (state_q != S_DONE);
      done      = (state_q == S_DONE);
      dbg_state = state_q;
   end

endmodule

// File: tb/tb_tap_bit_player.sv
// tb_tap_bit_player: checks the serial waveform cycle by cycle against a frame
// model, plus the read strobes, start latency, pause, rewind and reset behaviour.
module tb_tap_bit_player;

   localparam int H  = 4;
   localparam int SB = 3;
   localparam int PH_HI  = 0;
   localparam int PH_LO  = 1;
   localparam int PH_NX  = 2;
   localparam int PH_GAP = 3;

   logic        clk_sys = 1'b0;
   logic        RESET   = 1'b1;
   logic        rewind  = 1'b0;
   logic        en      = 1'b0;
   logic [24:0] tape_end = '0;
   logic [24:0] rd_addr;
   logic        rd_en;
   logic [7:0]  rd_data = '0;
   logic        data;
   logic        busy;
   logic        done;
   logic [2:0]  dbg_state;

   logic [7:0]  mem [0:15];
   logic [0:0]  exp_q [$];
   int          ph_q [$];
   int          bi_q [$];
   logic [24:0] rdq [$];
   logic [1:0]  en_hist = 2'b00;
   int          checks = 0;
   int          errors = 0;
   bit          rew;

   tap_bit_player #(.HALF_TICKS(H), .STOP_BITS(SB)) dut (
      .clk_sys   (clk_sys),
      .RESET     (RESET),
      .rewind    (rewind),
      .en        (en),
      .tape_end  (tape_end),
      .rd_addr   (rd_addr),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .data      (data),
      .busy      (busy),
      .done      (done),
      .dbg_state (dbg_state)
   );

   // clock / cache model / monitors
   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) begin
      if (rd_en) rd_data <= mem[rd_addr[3:0]];
      en_hist <= {en_hist[0], en};
   end

   always @(negedge clk_sys) begin
      if (rd_en) rdq.push_back(rd_addr);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Expected waveform in state time: per bit H highs, a low half, one NEXT low; 2 lows between bytes.
   task automatic build_stream(input int nbytes);
      logic frame [$];
      logic [7:0] v;
      exp_q.delete(); ph_q.delete(); bi_q.delete();
      for (int b = 0; b < nbytes; b++) begin
         v = mem[b];
         frame.delete();
         frame.push_back(1'b0);
         for (int i = 0; i < 8; i++) frame.push_back(v[i]);
         frame.push_back(($countones(v) % 2) == 0);
         for (int i = 0; i < SB; i++) frame.push_back(1'b1);
         for (int k = 0; k < frame.size(); k++) begin
            if (k == 0 && b > 0)
               for (int i = 0; i < 2; i++) begin exp_q.push_back(1'b0); ph_q.push_back(PH_GAP); bi_q.push_back(b); end
            for (int i = 0; i < H; i++) begin exp_q.push_back(1'b1); ph_q.push_back(PH_HI); bi_q.push_back(b); end
            for (int i = 0; i < (frame[k] ? H : 2 * H); i++) begin exp_q.push_back(1'b0); ph_q.push_back(PH_LO); bi_q.push_back(b); end
            exp_q.push_back(1'b0); ph_q.push_back(PH_NX); bi_q.push_back(b);
         end
      end
   endtask

   // Called at a negedge when the next posedge will see en=1 in IDLE.
   task automatic play(input int nbytes, input int pause_byte, input int rewind_byte, output bit rewound);
      int idx = 0;
      int cyc = 1;
      int guard = 0;
      int pause_cnt = 0;
      bit paused = 0;
      logic hold_data = 1'b0;
      rewound = 0;
      rdq.delete();
      @(posedge clk_sys);
      @(negedge clk_sys);
      check("rd_en_first_cycle", rd_en, 1);
      check("rd_addr_first", rd_addr, 0);
      while (data !== 1'b1 && cyc < 20) begin
         @(negedge clk_sys);
         cyc++;
      end
      check("start_latency_edges", cyc, 4);
      while (idx < exp_q.size() && guard < 20000) begin
         if (en_hist[1]) begin
            check("wave", data, exp_q[idx]);
            idx++;
         end
         if (pause_cnt > 0) begin
            pause_cnt--;
            if (pause_cnt == 0) begin
               check("pause_data_held", data, hold_data);
               check("pause_addr_held", rd_addr, pause_byte);
               check("pause_busy", busy, 1);
               en = 1'b1;
            end
         end else if (pause_byte >= 0 && !paused && idx >= 1 && idx < exp_q.size() &&
                      bi_q[idx] == pause_byte && ph_q[idx - 1] == PH_LO && ph_q[idx] == PH_LO) begin
            paused = 1;
            hold_data = data;
            en = 1'b0;
            pause_cnt = 50;
         end
         if (rewind_byte >= 0 && idx < exp_q.size() && bi_q[idx] == rewind_byte) begin
            rewind = 1'b1;
            @(negedge clk_sys);
            rewind = 1'b0;
            check("rewind_addr", rd_addr, 0);
            check("rewind_data", data, 0);
            check("rewind_busy", busy, 0);
            check("rewind_done", done, 0);
            rewound = 1;
            return;
         end
         @(negedge clk_sys);
         guard++;
      end
      check("stream_timeout", (guard >= 20000), 0);
      check("end_done", done, 1);
      check("end_data", data, 0);
      check("end_busy", busy, 0);
      check("rd_count", rdq.size(), nbytes);
      for (int i = 0; i < rdq.size() && i < nbytes; i++) check("rd_addr_seq", rdq[i], i);
   endtask

   task automatic leave_done();
      @(negedge clk_sys);
      en = 1'b0;
      rewind = 1'b1;
      @(negedge clk_sys);
      rewind = 1'b0;
      check("rewind_clears_done", done, 0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      check("reset_rd_addr", rd_addr, 0);
      check("reset_rd_en", rd_en, 0);
      check("reset_data", data, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      RESET = 1'b0;

      // single byte 0x16, tape_end=0
      mem[0] = 8'h16;
      tape_end = 25'd0;
      build_stream(1);
      en = 1'b1;
      play(1, -1, -1, rew);

      // RESET in DONE, then quiet with en low
      @(negedge clk_sys);
      en = 1'b0;
      RESET = 1'b1;
      @(negedge clk_sys);
      RESET = 1'b0;
      check("reset_in_done_done", done, 0);
      check("reset_in_done_busy", busy, 0);
      rdq.delete();
      repeat (100) @(negedge clk_sys);
      check("no_rd_en_idle", rdq.size(), 0);
      check("idle_data_low", data, 0);

      // parity corners 0x00 / 0xFF
      mem[0] = 8'h00;
      mem[1] = 8'hFF;
      tape_end = 25'd1;
      build_stream(2);
      en = 1'b1;
      play(2, -1, -1, rew);
      leave_done();

      // random bytes with a 50-cycle pause mid BIT_LO
      for (int i = 0; i < 6; i++) mem[i] = 8'($urandom_range(0, 255));
      tape_end = 25'd5;
      build_stream(6);
      en = 1'b1;
      play(6, 1, -1, rew);
      leave_done();

      // random bytes, rewind during byte 3, then full replay
      for (int i = 0; i < 6; i++) mem[i] = 8'($urandom_range(0, 255));
      build_stream(6);
      en = 1'b1;
      play(6, -1, 3, rew);
      check("rewind_taken", rew, 1);
      play(6, -1, -1, rew);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
